prom_programmer: RTL
====================

# prom_programmer

Write-side companion to the ROM reader. Programs one word of a fusible-link PROM (556PT5 / 3604 by default, 556PT4 / 3601 via parameters) per request. It drives the address, the V1–V4 operation bus and a one-hot bit-select, and issues timed programming pulses one bit at a time. Each pulse is verified by a read-back with bounded retries. It sits between the host/UART command layer and the chip socket drivers.

## Interface
Parameters:
- DATA_WIDTH, 8: word width (4 for 3601)
- ADDRESS_WIDTH, 9: address width (8 for 3601)
- SETTLE_CYCLES, 20: cycles address/operation held before read-back sample, and after each pulse; ≥1
- PULSE_CYCLES, 500: programming pulse length in clk cycles; ≥1
- MAX_RETRIES, 8: pulses allowed per bit before failure; 1..255

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- address_in  in  ADDRESS_WIDTH  target address, latched on accepted start
- data_in  in  DATA_WIDTH  target word (1 = bit to be fused), latched on accepted start
- data_line_in  in  DATA_WIDTH  read-back from chip
- address_line  out  ADDRESS_WIDTH  chip address
- operation  out  4  V1..V4 control, bit0=V1
- bit_select  out  DATA_WIDTH  one-hot output driver enable for the bit being fused
- busy  out  1  high from acceptance until return to IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  result flag, valid with done, held until next accepted start

## Operation
- Reset values: state IDLE, operation 4'b0000, bit_select 0, address_line 0, busy 0, done 0, error 0, retry counter 0.
- Operation codes: IDLE/DONE 4'b0000; read (SETTLE, CHECK, RECOVER) 4'b1100; program (PULSE) 4'b0011.
- IDLE: start=1 latches address_in/data_in, clears error, goes to SETTLE. start while busy is ignored.
- SETTLE: drives read code and the latched address for SETTLE_CYCLES cycles, then CHECK.
- CHECK (1 cycle): samples data_line_in into rb. pending = target & ~rb.
  - pending==0 → DONE, error=0.
  - Otherwise select idx = lowest set bit of pending.
  - If idx differs from the previous pulsed bit, the retry counter resets to 0.
  - If retry counter == MAX_RETRIES → DONE, error=1.
  - Else increment retry counter → PULSE.
- PULSE: operation 4'b0011, bit_select = 1<<idx, for exactly PULSE_CYCLES cycles; then RECOVER.
- RECOVER: bit_select 0, read code, SETTLE_CYCLES cycles, then CHECK.
- DONE: done=1 for one cycle, then IDLE.
- bit_select is nonzero only in PULSE.
- address_line holds the latched address through DONE.
- Bits read as 1 but targeted 0 are handled per Configuration.

## Timing
- Accepted start at edge 0: busy=1 and SETTLE from edge 1.
- CHECK occupies the cycle after edge SETTLE_CYCLES+1.
- No-pulse word: done high in the cycle after edge SETTLE_CYCLES+2; busy low after edge SETTLE_CYCLES+3.
- Each pulse adds PULSE_CYCLES + SETTLE_CYCLES + 1 cycles (PULSE, RECOVER, CHECK).
- reset_n=0 mid-operation: at the next edge operation=0000 and bit_select=0 (pulse aborted), IDLE, no done pulse.
- Read code is held one cycle before PULSE entry; there is no direct 0000↔0011 transition.

## Configuration
- PROM_PROGRAMMER_BLANK_CHECK_EN defined: the first CHECK after start computes (rb & ~target). If that is nonzero, go straight to DONE with error=1 and no pulse is issued, because blown fuses cannot be restored.
- Not defined: extra 1s are ignored. Success means only that every targeted bit reads 1.

## Test plan
All scenarios use SETTLE_CYCLES=4, PULSE_CYCLES=10, MAX_RETRIES=3, DATA_WIDTH=8.
- Already programmed: addr 9'h055, data 8'hA5, chip model returns 8'hA5 → zero pulses; done in the cycle after edge 6; error=0; bit_select never nonzero.
- Normal burn: data 8'h81 on a blank model (fuse blows on the first pulse) → exactly two pulses, bit_select 8'h01 then 8'h80, each 10 cycles with operation=0011; done, error=0.
- Stuck bit: model never fuses bit 2, data 8'h04 → exactly 3 pulses on 8'h04; done with error=1.
- Blank check: macro defined, model reads 8'h10, data 8'h01 → no pulse; error=1. Macro undefined → one pulse on bit 0; error=0.
- Reset mid-pulse: reset_n=0 on the 5th PULSE cycle → next edge shows operation=0000, bit_select=0, busy=0, no done pulse; a new start then works normally.
- Start while busy: a second start with addr 9'h1FF mid-operation is ignored; address_line keeps the first address until done.

Source files
------------

// File: rtl/prom_programmer.sv
`default_nettype none
// ============================================================================
// Module   : prom_programmer
// Brief    : Programs one fusible-link PROM word per request. Each bit gets a
//            timed pulse, followed by a read-back verify with bounded retries.
//            Optional macro PROM_PROGRAMMER_BLANK_CHECK_EN aborts a word when
//            the chip already has fuses blown outside the target pattern.
// Revision : 1.0 - initial release
// ============================================================================
module prom_programmer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9,
    parameter int SETTLE_CYCLES = 20,
    parameter int PULSE_CYCLES  = 500,
    parameter int MAX_RETRIES   = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [3:0]               operation,
    output logic [DATA_WIDTH-1:0]    bit_select,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);
    localparam int c_IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int c_CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST  = c_CNT_W'(PULSE_CYCLES - 1);
    localparam logic [7:0]         c_MAX_RETRY   = 8'(MAX_RETRIES);
    localparam logic [3:0]         c_OP_IDLE     = 4'b0000;
    localparam logic [3:0]         c_OP_READ     = 4'b1100;
    localparam logic [3:0]         c_OP_PROG     = 4'b0011;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CHECK   = 3'd2,
        S_PULSE   = 3'd3,
        S_RECOVER = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_target;
    logic [c_IDX_W-1:0]       r_idx;
    logic [7:0]               r_retry;
    logic                     r_error;

    logic [DATA_WIDTH-1:0]    w_pending;
    logic [c_IDX_W-1:0]       w_low_idx;
    logic [7:0]               w_retry_base;
    logic                     w_blank_fail;
    logic                     w_check_err;

    // Priority scan from the top so the lowest pending bit wins.
    always_comb begin
        w_pending = r_target & ~data_line_in;
        w_low_idx = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (w_pending[i]) w_low_idx = c_IDX_W'(i);
        end
    end

    // r_idx holds the last pulsed bit; retry is zeroed on start so a stale idx is harmless.
    assign w_retry_base = (w_low_idx == r_idx) ? r_retry : 8'd0;
    assign w_check_err  = w_blank_fail || ((w_pending != '0) && (w_retry_base == c_MAX_RETRY));

`ifdef PROM_PROGRAMMER_BLANK_CHECK_EN
    logic r_first;
    always_ff @(posedge clk) begin
        if (!reset_n)                          r_first <= 1'b0;
        else if (r_state == S_IDLE && start)   r_first <= 1'b1;
        else if (r_state == S_CHECK)           r_first <= 1'b0;
    end
    assign w_blank_fail = r_first && ((data_line_in & ~r_target) != '0);
`else
    assign w_blank_fail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        operation    = c_OP_IDLE;
        bit_select   = '0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next_state = S_SETTLE;
            end
            S_SETTLE: begin
                operation = c_OP_READ;
                if (r_cnt == c_SETTLE_LAST) w_next_state = S_CHECK;
            end
            S_CHECK: begin
                operation = c_OP_READ;
                if ((w_pending == '0) || w_check_err) w_next_state = S_DONE;
                else                                  w_next_state = S_PULSE;
            end
            S_PULSE: begin
                operation  = c_OP_PROG;
                bit_select = DATA_WIDTH'(1) << r_idx;
                if (r_cnt == c_PULSE_LAST) w_next_state = S_RECOVER;
            end
            S_RECOVER: begin
                operation = c_OP_READ;
                if (r_cnt == c_SETTLE_LAST) w_next_state = S_CHECK;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_target <= '0;
            r_idx    <= '0;
            r_retry  <= 8'd0;
            r_error  <= 1'b0;
        end else begin
            if (w_next_state != r_state) r_cnt <= '0;
            else if (r_state == S_SETTLE || r_state == S_PULSE || r_state == S_RECOVER)
                r_cnt <= r_cnt + c_CNT_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr   <= address_in;
                        r_target <= data_in;
                        r_error  <= 1'b0;
                        r_retry  <= 8'd0;
                    end
                end
                S_CHECK: begin
                    if (w_next_state == S_DONE) begin
                        r_error <= w_check_err;
                    end else begin
                        r_idx   <= w_low_idx;
                        r_retry <= w_retry_base + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign address_line = r_addr;
    assign error        = r_error;

endmodule
`default_nettype wire
